// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch traceback decode path:
// alignment op encodings, grid traceback direction codes, default weights
// and the decoder state encoding.
package nw_pkg;

    // Alignment operation codes carried on out_op.
    localparam logic [1:0] OP_MATCH    = 2'b00;
    localparam logic [1:0] OP_MISMATCH = 2'b01;
    localparam logic [1:0] OP_INS      = 2'b10;  // gap in s1, s2 char consumed
    localparam logic [1:0] OP_DEL      = 2'b11;  // gap in s2, s1 char consumed

    // Grid traceback directions. TOP moves one row up (DEL), LEFT moves
    // one column left (INS), CORNER moves diagonally (MATCH/MISMATCH).
    localparam logic [1:0] TOP_DIR    = 2'b01;
    localparam logic [1:0] LEFT_DIR   = 2'b10;
    localparam logic [1:0] CORNER_DIR = 2'b11;

    // Default scoring weights, identical to the grid's.
    localparam int DEF_MATCH    = 1;
    localparam int DEF_INDEL    = -1;
    localparam int DEF_MISMATCH = -1;

    // Decoder control states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } dec_state_t;

endpackage

// File: rtl/nw_step_classify.sv
// Combinational classifier for one traceback step prev -> cur.
// The step is legal only when cur lies inside the grid and cur is exactly
// one cell left, up, or diagonally up-left of prev. c1_in/c2_in are the
// characters at prev (s1[prev.y], s2[prev.x]); the gap side is zeroed.
module nw_step_classify
    import nw_pkg::*;
#(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int CORD_LENGTH = 8
) (
    input  logic [CORD_LENGTH-1:0] prev_x,
    input  logic [CORD_LENGTH-1:0] prev_y,
    input  logic [CORD_LENGTH-1:0] cur_x,
    input  logic [CORD_LENGTH-1:0] cur_y,
    input  logic [CWIDTH-1:0]      c1_in,
    input  logic [CWIDTH-1:0]      c2_in,
    output logic [1:0]             op,
    output logic [CWIDTH-1:0]      c1,
    output logic [CWIDTH-1:0]      c2,
    output logic                   illegal
);

    localparam logic [CORD_LENGTH-1:0] LIM = CORD_LENGTH'(LENGTH);
    localparam logic [CORD_LENGTH-1:0] ONE = CORD_LENGTH'(1);

    logic [CORD_LENGTH-1:0] dx;
    logic [CORD_LENGTH-1:0] dy;
    logic                   out_of_range;

    // Deltas wrap modulo 2^CORD_LENGTH, so the range check must come first.
    assign dx           = prev_x - cur_x;
    assign dy           = prev_y - cur_y;
    assign out_of_range = (cur_x >= LIM) || (cur_y >= LIM);

    // Map the step delta to an alignment op; anything else is illegal.
    always_comb begin
        op      = OP_MATCH;
        c1      = '0;
        c2      = '0;
        illegal = 1'b0;
        if (out_of_range) begin
            illegal = 1'b1;
        end else if (dx == ONE && dy == ONE) begin
            op = (c1_in == c2_in) ? OP_MATCH : OP_MISMATCH;
            c1 = c1_in;
            c2 = c2_in;
        end else if (dx == ONE && dy == '0) begin
            op = OP_INS;
            c2 = c2_in;
        end else if (dx == '0 && dy == ONE) begin
            op = OP_DEL;
            c1 = c1_in;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/nw_align_decoder.sv
// Converts the Needleman-Wunsch traceback coordinate stream (starting at
// (LENGTH-1, LENGTH-1), ending at (0,0)) into a per-column alignment op
// stream with the aligned characters.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high; valid never depends combinationally on ready, and a
// presented op holds stable until taken. in_ready depends on out_ready only
// so that the single output register can be refilled in the cycle it drains.
//
// Optional feature: define NW_ALIGN_DECODER_SCORE_EN to accumulate the
// alignment score over consumed ops; otherwise score is tied to 0.
module nw_align_decoder
    import nw_pkg::*;
#(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int SWIDTH      = 16,
    parameter int CORD_LENGTH = 8,
    parameter int MATCH       = DEF_MATCH,
    parameter int INDEL       = DEF_INDEL,
    parameter int MISMATCH    = DEF_MISMATCH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CORD_LENGTH-1:0]   in_x,
    input  logic [CORD_LENGTH-1:0]   in_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_op,
    output logic [CWIDTH-1:0]        out_c1,
    output logic [CWIDTH-1:0]        out_c2,
    output logic                     out_last,
    output logic                     done,
    output logic                     error,
    output logic signed [SWIDTH-1:0] score,
    output logic [2:0]               dbg_state
);

    localparam logic [CORD_LENGTH-1:0] LAST = CORD_LENGTH'(LENGTH - 1);

    dec_state_t             state, state_next;
    logic [CORD_LENGTH-1:0] prev_x, prev_y;
    logic [CWIDTH-1:0]      c1_sel, c2_sel;
    logic [1:0]             cls_op;
    logic [CWIDTH-1:0]      cls_c1, cls_c2;
    logic                   cls_illegal;
    logic                   out_free;
    logic                   accept;
    logic                   cur_origin;
    logic                   ld_prev, ld_step, ld_flush, drop;

    assign dbg_state  = state;
    assign out_free   = !out_valid || out_ready;
    assign cur_origin = (in_x == '0) && (in_y == '0);

    // Pick the characters at prev; constant-index mux keeps index widths exact.
    always_comb begin
        c1_sel = '0;
        c2_sel = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (prev_y == CORD_LENGTH'(i)) c1_sel = s1[i*CWIDTH +: CWIDTH];
            if (prev_x == CORD_LENGTH'(i)) c2_sel = s2[i*CWIDTH +: CWIDTH];
        end
    end

    nw_step_classify #(
        .LENGTH      (LENGTH),
        .CWIDTH      (CWIDTH),
        .CORD_LENGTH (CORD_LENGTH)
    ) u_classify (
        .prev_x  (prev_x),
        .prev_y  (prev_y),
        .cur_x   (in_x),
        .cur_y   (in_y),
        .c1_in   (c1_sel),
        .c2_in   (c2_sel),
        .op      (cls_op),
        .c1      (cls_c1),
        .c2      (cls_c2),
        .illegal (cls_illegal)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next state, datapath load strobes and level outputs; start overrides all.
    always_comb begin
        state_next = state;
        ld_prev    = 1'b0;
        ld_step    = 1'b0;
        ld_flush   = 1'b0;
        drop       = 1'b0;
        in_ready   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_FIRST, S_RUN: in_ready = out_free;
            S_DONE:         done     = 1'b1;
            S_ERR:          error    = 1'b1;
            default:        ;
        endcase
        accept = in_valid && in_ready;

        if (start) begin
            state_next = S_FIRST;
            drop       = 1'b1;
        end else begin
            case (state)
                S_FIRST: begin
                    if (accept) begin
                        if (in_x == LAST && in_y == LAST) begin
                            ld_prev    = 1'b1;
                            state_next = cur_origin ? S_FLUSH : S_RUN;
                        end else begin
                            drop       = 1'b1;
                            state_next = S_ERR;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (cls_illegal) begin
                            drop       = 1'b1;
                            state_next = S_ERR;
                        end else begin
                            ld_step    = 1'b1;
                            ld_prev    = 1'b1;
                            if (cur_origin) state_next = S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // out_last marks that the (0,0) op is already in the register.
                    if (out_valid && out_last) begin
                        if (out_ready) state_next = S_DONE;
                    end else if (out_free) begin
                        ld_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Previous-coordinate register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_x <= '0;
            prev_y <= '0;
        end else if (ld_prev) begin
            prev_x <= in_x;
            prev_y <= in_y;
        end
    end

    // Single output register: drop, load a step op, load the (0,0) op, or drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_c1    <= '0;
            out_c2    <= '0;
            out_last  <= 1'b0;
        end else if (drop) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_c1    <= '0;
            out_c2    <= '0;
            out_last  <= 1'b0;
        end else if (ld_step) begin
            out_valid <= 1'b1;
            out_op    <= cls_op;
            out_c1    <= cls_c1;
            out_c2    <= cls_c2;
            out_last  <= 1'b0;
        end else if (ld_flush) begin
            out_valid <= 1'b1;
            out_op    <= (s1[CWIDTH-1:0] == s2[CWIDTH-1:0]) ? OP_MATCH : OP_MISMATCH;
            out_c1    <= s1[CWIDTH-1:0];
            out_c2    <= s2[CWIDTH-1:0];
            out_last  <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NW_ALIGN_DECODER_SCORE_EN
    logic signed [SWIDTH-1:0] weight;
    logic signed [SWIDTH-1:0] score_q;

    // Weight of the op currently presented.
    always_comb begin
        case (out_op)
            OP_MATCH:    weight = SWIDTH'(MATCH);
            OP_MISMATCH: weight = SWIDTH'(MISMATCH);
            default:     weight = SWIDTH'(INDEL);
        endcase
    end

    // Wrap-around accumulation over every consumed op; start clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       score_q <= '0;
        else if (start)                   score_q <= '0;
        else if (out_valid && out_ready)  score_q <= score_q + weight;
    end

    assign score = score_q;
`else
    logic unused_weights;
    assign unused_weights = ^{MATCH[0], INDEL[0], MISMATCH[0]};
    assign score          = '0;
`endif

endmodule
